// File: rtl/pit_write_sequencer.sv
// 8254 bus-write sequencer: decodes control words and count bytes into the
// per-counter load handshake (selector, count byte, two-byte flag, NEW_COUNT).
module pit_write_sequencer #(
  parameter int LOAD_HOLD = 2,
  parameter int NUM_CNT   = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CS_N,
  input  logic       WR_N,
  input  logic [1:0] A,
  input  logic [7:0] D,
  output logic [2:0] COUNTER_SELECTOR,
  output logic [7:0] INITIAL_COUNT,
  output logic       COUNT_BYTE_SEL,
  output logic [2:0] TWO_BYTE_COUNTER,
  output logic [2:0] NEW_COUNT,
  output logic [8:0] MODE,
  output logic [2:0] BCD,
  output logic [2:0] LATCH
);

  logic                        wr_prev_q, wr_prev_d;
  logic [NUM_CNT-1:0][1:0]     rw_q, rw_d;
  logic [NUM_CNT-1:0][2:0]     mode_q, mode_d;
  logic [NUM_CNT-1:0]          bcd_q, bcd_d;
  logic [NUM_CNT-1:0]          ptr_q, ptr_d;
  logic [NUM_CNT-1:0]          sel_q, sel_d;
  logic [7:0]                  init_q, init_d;
  logic                        byte_sel_q, byte_sel_d;
  logic [NUM_CNT-1:0]          two_byte_q, two_byte_d;
  logic [NUM_CNT-1:0]          new_count_q, new_count_d;
  logic [NUM_CNT-1:0]          latch_q, latch_d;
  logic [3:0]                  hold_cnt_q, hold_cnt_d;
  logic [1:0]                  hold_own_q, hold_own_d;
  logic                        wr_evt;
  logic                        final_byte;
  logic [1:0]                  sc;
  logic [1:0]                  rw_new;

  assign wr_evt = !CS_N && !WR_N && wr_prev_q;
  assign sc     = D[7:6];
  assign rw_new = D[5:4];

  always_comb begin
    wr_prev_d   = WR_N;
    rw_d        = rw_q;
    mode_d      = mode_q;
    bcd_d       = bcd_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    init_d      = init_q;
    byte_sel_d  = byte_sel_q;
    two_byte_d  = two_byte_q;
    new_count_d = new_count_q;
    latch_d     = '0;
    hold_cnt_d  = hold_cnt_q;
    hold_own_d  = hold_own_q;
    final_byte  = 1'b0;

    // Hold countdown; a write event below may override the release.
    if (hold_cnt_q != 4'd0) begin
      if (hold_cnt_q == 4'd1) begin
        new_count_d[hold_own_q] = 1'b1;
        hold_cnt_d              = 4'd0;
      end else begin
        hold_cnt_d = hold_cnt_q - 4'd1;
      end
    end

    if (wr_evt) begin
      if (A == 2'b11) begin
        if (sc != 2'b11) begin
          if (rw_new == 2'b00) begin
            latch_d[sc] = 1'b1;
          end else begin
            rw_d[sc]        = rw_new;
            mode_d[sc]      = (D[3:2] == 2'b11) ? {1'b0, D[2:1]} : D[3:1];
            bcd_d[sc]       = D[0];
            ptr_d[sc]       = 1'b0;
            two_byte_d[sc]  = (rw_new == 2'b11);
            new_count_d[sc] = 1'b0;
            if (hold_cnt_q != 4'd0 && hold_own_q == sc) begin
              hold_cnt_d = 4'd0;
            end
          end
        end
      end else if (rw_q[A] != 2'b00) begin
        // Any accepted count write ends the current hold; another owner is released now.
        if (hold_cnt_q != 4'd0 && hold_own_q != A) begin
          new_count_d[hold_own_q] = 1'b1;
        end
        hold_cnt_d     = 4'd0;
        sel_d          = 3'b001 << A;
        init_d         = D;
        new_count_d[A] = 1'b0;
        case (rw_q[A])
          2'b01: begin
            byte_sel_d = 1'b0;
            final_byte = 1'b1;
          end
          2'b10: begin
            byte_sel_d = 1'b1;
            final_byte = 1'b1;
          end
          default: begin
            byte_sel_d = ptr_q[A];
            final_byte = ptr_q[A];
            ptr_d[A]   = !ptr_q[A];
          end
        endcase
        if (final_byte) begin
          hold_cnt_d = 4'(LOAD_HOLD);
          hold_own_d = A;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_prev_q   <= 1'b1;
      rw_q        <= '0;
      mode_q      <= '0;
      bcd_q       <= '0;
      ptr_q       <= '0;
      sel_q       <= '0;
      init_q      <= '0;
      byte_sel_q  <= 1'b0;
      two_byte_q  <= '0;
      new_count_q <= '1;
      latch_q     <= '0;
      hold_cnt_q  <= '0;
      hold_own_q  <= '0;
    end else begin
      wr_prev_q   <= wr_prev_d;
      rw_q        <= rw_d;
      mode_q      <= mode_d;
      bcd_q       <= bcd_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      init_q      <= init_d;
      byte_sel_q  <= byte_sel_d;
      two_byte_q  <= two_byte_d;
      new_count_q <= new_count_d;
      latch_q     <= latch_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_own_q  <= hold_own_d;
    end
  end

  assign COUNTER_SELECTOR = sel_q;
  assign INITIAL_COUNT    = init_q;
  assign COUNT_BYTE_SEL   = byte_sel_q;
  assign TWO_BYTE_COUNTER = two_byte_q;
  assign NEW_COUNT        = new_count_q;
  assign MODE             = mode_q;
  assign BCD              = bcd_q;
  assign LATCH            = latch_q;

endmodule

// File: tb/tb_pit_write_sequencer.sv
// Directed bench for pit_write_sequencer: default instance plus a LOAD_HOLD=5
// instance on the same bus so preemption is distinguishable from a natural release.
module tb_pit_write_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       CS_N;
  logic       WR_N;
  logic [1:0] A;
  logic [7:0] D;

  logic [2:0] cs_o, tb_o, nc_o, bcd_o, lat_o;
  logic [7:0] ic_o;
  logic       bs_o;
  logic [8:0] mode_o;

  logic [2:0] cs5, tb5, nc5, bcd5, lat5;
  logic [7:0] ic5;
  logic       bs5;
  logic [8:0] mode5;

  int n_cmp;
  int n_bad;

  pit_write_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .CS_N(CS_N), .WR_N(WR_N), .A(A), .D(D),
    .COUNTER_SELECTOR(cs_o), .INITIAL_COUNT(ic_o), .COUNT_BYTE_SEL(bs_o),
    .TWO_BYTE_COUNTER(tb_o), .NEW_COUNT(nc_o), .MODE(mode_o), .BCD(bcd_o),
    .LATCH(lat_o)
  );

  pit_write_sequencer #(.LOAD_HOLD(5)) dut5 (
    .CLK(CLK), .RST_N(RST_N), .CS_N(CS_N), .WR_N(WR_N), .A(A), .D(D),
    .COUNTER_SELECTOR(cs5), .INITIAL_COUNT(ic5), .COUNT_BYTE_SEL(bs5),
    .TWO_BYTE_COUNTER(tb5), .NEW_COUNT(nc5), .MODE(mode5), .BCD(bcd5),
    .LATCH(lat5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One write event; returns 1 time unit after the sampling edge with WR_N still low.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK);
    A = a; D = d; CS_N = 1'b0; WR_N = 1'b0;
    @(posedge CLK); #1;
    $display("wr A=%0d D=%02h -> sel=%b ic=%02h bs=%b nc=%b lat=%b", a, d, cs_o, ic_o, bs_o, nc_o, lat_o);
  endtask

  task automatic step();
    @(negedge CLK);
    CS_N = 1'b1; WR_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; CS_N = 1'b1; WR_N = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (cs_o !== 3'b000) begin n_bad++; $display("FAIL reset_sel got %b exp 000", cs_o); end
    n_cmp++; if (ic_o !== 8'h00) begin n_bad++; $display("FAIL reset_ic got %h exp 00", ic_o); end
    n_cmp++; if (bs_o !== 1'b0) begin n_bad++; $display("FAIL reset_bs got %b exp 0", bs_o); end
    n_cmp++; if (tb_o !== 3'b000) begin n_bad++; $display("FAIL reset_two_byte got %b exp 000", tb_o); end
    n_cmp++; if (nc_o !== 3'b111) begin n_bad++; $display("FAIL reset_nc got %b exp 111", nc_o); end
    n_cmp++; if (mode_o !== 9'h000) begin n_bad++; $display("FAIL reset_mode got %h exp 000", mode_o); end
    n_cmp++; if (bcd_o !== 3'b000) begin n_bad++; $display("FAIL reset_bcd got %b exp 000", bcd_o); end
    n_cmp++; if (lat_o !== 3'b000) begin n_bad++; $display("FAIL reset_latch got %b exp 000", lat_o); end
  endtask

  task automatic test_lsb_only();
    wr(2'b11, 8'h10);
    n_cmp++; if (nc_o !== 3'b110) begin n_bad++; $display("FAIL ctrl0_nc got %b exp 110", nc_o); end
    step();
    wr(2'b00, 8'h03);
    n_cmp++; if (cs_o !== 3'b001) begin n_bad++; $display("FAIL lsb_sel got %b exp 001", cs_o); end
    n_cmp++; if (ic_o !== 8'h03) begin n_bad++; $display("FAIL lsb_ic got %h exp 03", ic_o); end
    n_cmp++; if (bs_o !== 1'b0) begin n_bad++; $display("FAIL lsb_bs got %b exp 0", bs_o); end
    n_cmp++; if (nc_o[0] !== 1'b0) begin n_bad++; $display("FAIL lsb_nc_e0 got %b exp 0", nc_o[0]); end
    step();
    n_cmp++; if (nc_o[0] !== 1'b0) begin n_bad++; $display("FAIL lsb_nc_e1 got %b exp 0", nc_o[0]); end
    step();
    n_cmp++; if (nc_o[0] !== 1'b1) begin n_bad++; $display("FAIL lsb_nc_e2 got %b exp 1", nc_o[0]); end
    n_cmp++; if (tb_o[0] !== 1'b0) begin n_bad++; $display("FAIL lsb_two_byte got %b exp 0", tb_o[0]); end
    n_cmp++; if (mode_o[2:0] !== 3'b000) begin n_bad++; $display("FAIL lsb_mode got %b exp 000", mode_o[2:0]); end
    n_cmp++; if (ic_o !== 8'h03) begin n_bad++; $display("FAIL lsb_ic_stable got %h exp 03", ic_o); end
    // Same-counter rewrite during its hold reloads the hold.
    wr(2'b00, 8'h21);
    step();
    wr(2'b00, 8'h22);
    n_cmp++; if (nc_o[0] !== 1'b0) begin n_bad++; $display("FAIL reload_nc_e0 got %b exp 0", nc_o[0]); end
    step();
    n_cmp++; if (nc_o[0] !== 1'b0) begin n_bad++; $display("FAIL reload_nc_e1 got %b exp 0", nc_o[0]); end
    step();
    n_cmp++; if (nc_o[0] !== 1'b1) begin n_bad++; $display("FAIL reload_nc_e2 got %b exp 1", nc_o[0]); end
  endtask

  task automatic test_two_byte();
    wr(2'b11, 8'h70);
    n_cmp++; if (tb_o[1] !== 1'b1) begin n_bad++; $display("FAIL tb_two_byte got %b exp 1", tb_o[1]); end
    n_cmp++; if (nc_o[1] !== 1'b0) begin n_bad++; $display("FAIL tb_ctrl_nc got %b exp 0", nc_o[1]); end
    step();
    wr(2'b01, 8'h00);
    n_cmp++; if (cs_o !== 3'b010) begin n_bad++; $display("FAIL tb_lsb_sel got %b exp 010", cs_o); end
    n_cmp++; if (ic_o !== 8'h00) begin n_bad++; $display("FAIL tb_lsb_ic got %h exp 00", ic_o); end
    n_cmp++; if (bs_o !== 1'b0) begin n_bad++; $display("FAIL tb_lsb_bs got %b exp 0", bs_o); end
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (nc_o[1] !== 1'b0) begin n_bad++; $display("FAIL tb_mid_nc got %b exp 0", nc_o[1]); end
    wr(2'b01, 8'h01);
    n_cmp++; if (ic_o !== 8'h01) begin n_bad++; $display("FAIL tb_msb_ic got %h exp 01", ic_o); end
    n_cmp++; if (bs_o !== 1'b1) begin n_bad++; $display("FAIL tb_msb_bs got %b exp 1", bs_o); end
    step();
    n_cmp++; if (nc_o[1] !== 1'b0) begin n_bad++; $display("FAIL tb_msb_nc_e1 got %b exp 0", nc_o[1]); end
    step();
    n_cmp++; if (nc_o[1] !== 1'b1) begin n_bad++; $display("FAIL tb_msb_nc_e2 got %b exp 1", nc_o[1]); end
  endtask

  task automatic test_mode_latch();
    wr(2'b11, 8'hBC);
    n_cmp++; if (mode_o !== 9'b010_000_000) begin n_bad++; $display("FAIL ml_mode got %b exp 010000000", mode_o); end
    n_cmp++; if (nc_o !== 3'b011) begin n_bad++; $display("FAIL ml_nc got %b exp 011", nc_o); end
    n_cmp++; if (tb_o !== 3'b110) begin n_bad++; $display("FAIL ml_two_byte got %b exp 110", tb_o); end
    step();
    wr(2'b11, 8'h80);
    n_cmp++; if (lat_o !== 3'b100) begin n_bad++; $display("FAIL ml_latch got %b exp 100", lat_o); end
    n_cmp++; if (mode_o !== 9'b010_000_000) begin n_bad++; $display("FAIL ml_latch_mode got %b exp 010000000", mode_o); end
    n_cmp++; if (nc_o !== 3'b011) begin n_bad++; $display("FAIL ml_latch_nc got %b exp 011", nc_o); end
    step();
    n_cmp++; if (lat_o !== 3'b000) begin n_bad++; $display("FAIL ml_latch_end got %b exp 000", lat_o); end
    wr(2'b11, 8'h75);
    n_cmp++; if (bcd_o !== 3'b010) begin n_bad++; $display("FAIL ml_bcd got %b exp 010", bcd_o); end
    n_cmp++; if (mode_o !== 9'b010_010_000) begin n_bad++; $display("FAIL ml_mode1 got %b exp 010010000", mode_o); end
    step();
  endtask

  task automatic test_no_retrigger();
    wr(2'b00, 8'h0C);
    @(posedge CLK); #1;
    n_cmp++; if (nc_o[0] !== 1'b0) begin n_bad++; $display("FAIL nrt_nc_e1 got %b exp 0", nc_o[0]); end
    @(posedge CLK); #1;
    n_cmp++; if (nc_o[0] !== 1'b1) begin n_bad++; $display("FAIL nrt_nc_e2 got %b exp 1", nc_o[0]); end
    @(posedge CLK); #1;
    n_cmp++; if (nc_o[0] !== 1'b1) begin n_bad++; $display("FAIL nrt_nc_e3 got %b exp 1", nc_o[0]); end
    step();
  endtask

  task automatic test_ignored();
    do_reset();
    wr(2'b10, 8'h55);
    n_cmp++; if (cs_o !== 3'b000) begin n_bad++; $display("FAIL ign_sel got %b exp 000", cs_o); end
    n_cmp++; if (ic_o !== 8'h00) begin n_bad++; $display("FAIL ign_ic got %h exp 00", ic_o); end
    n_cmp++; if (nc_o !== 3'b111) begin n_bad++; $display("FAIL ign_nc got %b exp 111", nc_o); end
    step();
    wr(2'b11, 8'hC0);
    n_cmp++; if (mode_o !== 9'h000) begin n_bad++; $display("FAIL rb_mode got %h exp 000", mode_o); end
    n_cmp++; if (nc_o !== 3'b111) begin n_bad++; $display("FAIL rb_nc got %b exp 111", nc_o); end
    n_cmp++; if (lat_o !== 3'b000) begin n_bad++; $display("FAIL rb_latch got %b exp 000", lat_o); end
    n_cmp++; if (tb_o !== 3'b000) begin n_bad++; $display("FAIL rb_two_byte got %b exp 000", tb_o); end
    step();
  endtask

  task automatic test_preempt();
    wr(2'b11, 8'h10);
    step();
    wr(2'b11, 8'h50);
    step();
    wr(2'b00, 8'h0C);
    step();
    n_cmp++; if (nc5 !== 3'b100) begin n_bad++; $display("FAIL pre_hold_nc got %b exp 100", nc5); end
    wr(2'b01, 8'h22);
    n_cmp++; if (nc5 !== 3'b101) begin n_bad++; $display("FAIL pre_nc got %b exp 101", nc5); end
    n_cmp++; if (cs5 !== 3'b010) begin n_bad++; $display("FAIL pre_sel got %b exp 010", cs5); end
    n_cmp++; if (ic5 !== 8'h22) begin n_bad++; $display("FAIL pre_ic got %h exp 22", ic5); end
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (nc5[1] !== 1'b0) begin n_bad++; $display("FAIL pre_c1_e4 got %b exp 0", nc5[1]); end
    step();
    n_cmp++; if (nc5[1] !== 1'b1) begin n_bad++; $display("FAIL pre_c1_e5 got %b exp 1", nc5[1]); end
  endtask

  task automatic test_reset_mid();
    wr(2'b11, 8'h70);
    step();
    wr(2'b01, 8'hAA);
    step();
    #2 RST_N = 1'b0;
    #1;
    n_cmp++; if (nc_o !== 3'b111) begin n_bad++; $display("FAIL rm_nc got %b exp 111", nc_o); end
    n_cmp++; if (cs_o !== 3'b000) begin n_bad++; $display("FAIL rm_sel got %b exp 000", cs_o); end
    n_cmp++; if (ic_o !== 8'h00) begin n_bad++; $display("FAIL rm_ic got %h exp 00", ic_o); end
    n_cmp++; if (tb_o !== 3'b000) begin n_bad++; $display("FAIL rm_two_byte got %b exp 000", tb_o); end
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    wr(2'b01, 8'hBB);
    n_cmp++; if (cs_o !== 3'b000) begin n_bad++; $display("FAIL rm_ign_sel got %b exp 000", cs_o); end
    n_cmp++; if (nc_o !== 3'b111) begin n_bad++; $display("FAIL rm_ign_nc got %b exp 111", nc_o); end
    step();
    wr(2'b11, 8'h70);
    step();
    wr(2'b01, 8'h11);
    n_cmp++; if (bs_o !== 1'b0) begin n_bad++; $display("FAIL rm_ptr_bs got %b exp 0", bs_o); end
    n_cmp++; if (ic_o !== 8'h11) begin n_bad++; $display("FAIL rm_ptr_ic got %h exp 11", ic_o); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST_N = 1'b0;
    CS_N  = 1'b1;
    WR_N  = 1'b1;
    A     = 2'b00;
    D     = 8'h00;
    test_reset();
    test_lsb_only();
    test_two_byte();
    test_mode_latch();
    test_no_retrigger();
    test_ignored();
    test_preempt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
